// File: rtl/hex_rotate_sequencer_if.sv
// Bus between the HEX rotation sequencer and whatever drives it.
// Control inputs from the driver:
//   RUN (auto-rotate level), DIR (0 = increment, 1 = decrement),
//   STEP (manual step level), LOAD (load strobe), LOAD_VAL[1:0].
// Outputs from the sequencer:
//   OFFSET[1:0], CODE3..CODE0[1:0] (per-digit char codes),
//   TICK (one-cycle change pulse), RUNNING (FSM in RUN).
interface hex_rotate_sequencer_if;
  logic       RUN;
  logic       DIR;
  logic       STEP;
  logic       LOAD;
  logic [1:0] LOAD_VAL;
  logic [1:0] OFFSET;
  logic [1:0] CODE3;
  logic [1:0] CODE2;
  logic [1:0] CODE1;
  logic [1:0] CODE0;
  logic       TICK;
  logic       RUNNING;

  modport master (
    output RUN, DIR, STEP, LOAD, LOAD_VAL,
    input  OFFSET, CODE3, CODE2, CODE1, CODE0, TICK, RUNNING
  );

  modport slave (
    input  RUN, DIR, STEP, LOAD, LOAD_VAL,
    output OFFSET, CODE3, CODE2, CODE1, CODE0, TICK, RUNNING
  );
endinterface

// File: rtl/hex_rotate_sequencer.sv
// Rotation-offset sequencer for the 4-digit HEX character rotation path.
// Advances a 2-bit offset on a prescaled timer (RUN state), on a rising
// edge of STEP, or loads it directly; drives per-digit char codes.
// Ports:
//   CLOCK_50 - system clock (rising edge)
//   RESET    - synchronous active-high reset
//   bus      - hex_rotate_sequencer_if.slave (controls in, offset/codes/status out)
module hex_rotate_sequencer #(
  parameter int unsigned PRESCALE = 50000000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic                   CLOCK_50,
  input  logic                   RESET,
  hex_rotate_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

  typedef enum logic {
    ST_HOLD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       offset_q, offset_d;
  logic             step_q;
  logic             tick_q, tick_d;
  logic             step_req_c;
  logic             wrap_c;

  // FSM state register
  always_ff @(posedge CLOCK_50) begin
    if (RESET) state_q <= ST_HOLD;
    else       state_q <= state_d;
  end

  // Next-state: RUN level selects the state directly
  always_comb begin
    state_d = state_q;
    if (bus.RUN) state_d = ST_RUN;
    else         state_d = ST_HOLD;
  end

  // Prescaler / offset / tick next values
  always_comb begin
    cnt_d      = cnt_q;
    offset_d   = offset_q;
    step_req_c = bus.STEP & ~step_q;
    // Counter only runs while staying in RUN; leaving RUN freezes it
    wrap_c     = (state_q == ST_RUN) && bus.RUN && (cnt_q == CNT_LAST);

    if (state_q == ST_RUN && bus.RUN) begin
      cnt_d = wrap_c ? '0 : cnt_q + CNT_W'(1);
    end else if (state_q == ST_HOLD && bus.RUN) begin
      cnt_d = '0;
    end

    // LOAD beats step, step beats wrap; step and wrap together give one advance
    if (bus.LOAD) begin
      offset_d = bus.LOAD_VAL;
      cnt_d    = '0;
    end else if (step_req_c || wrap_c) begin
      offset_d = bus.DIR ? offset_q - 2'd1 : offset_q + 2'd1;
      if (step_req_c && state_q == ST_RUN) cnt_d = '0;
    end

    tick_d = (offset_d != offset_q);
  end

  // Datapath registers
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      cnt_q    <= '0;
      offset_q <= 2'd0;
      step_q   <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      offset_q <= offset_d;
      step_q   <= bus.STEP;
      tick_q   <= tick_d;
    end
  end

  // Codes are decoded from the registered offset only
  assign bus.OFFSET  = offset_q;
  assign bus.CODE3   = offset_q;
  assign bus.CODE2   = offset_q + 2'd1;
  assign bus.CODE1   = offset_q + 2'd2;
  assign bus.CODE0   = offset_q + 2'd3;
  assign bus.TICK    = tick_q;
  assign bus.RUNNING = (state_q == ST_RUN);

endmodule

// File: tb/tb_hex_rotate_sequencer.sv
module tb_hex_rotate_sequencer;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  hex_rotate_sequencer_if bus ();

  hex_rotate_sequencer #(
    .PRESCALE (4),
    .CNT_W    (3)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle past the edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] obs();
    return {bus.OFFSET, bus.CODE3, bus.CODE2, bus.CODE1, bus.CODE0, bus.TICK, bus.RUNNING};
  endfunction

  // Expected {OFFSET, CODE3..CODE0, TICK, RUNNING}; codes are offset+0..3 mod 4
  function automatic logic [11:0] expv(input logic [1:0] off, input logic tk, input logic rn);
    logic [1:0] c2, c1, c0;
    c2 = off + 2'd1;
    c1 = off + 2'd2;
    c0 = off + 2'd3;
    return {off, off, c2, c1, c0, tk, rn};
  endfunction

  task automatic test_reset();
    logic [11:0] o, e;
    logic [7:0]  codes;
    rst = 1'b1;
    cyc();
    cyc();
    o = obs(); e = expv(2'd0, 1'b0, 1'b0);
    total_cnt++;
    if (o !== e) $display("FAIL reset_state: got %h expected %h", o, e);
    else pass_cnt++;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      o = obs();
      total_cnt++;
      if (o !== e) $display("FAIL reset_hold cyc%0d: got %h expected %h", i, o, e);
      else pass_cnt++;
    end
    codes = {bus.CODE3, bus.CODE2, bus.CODE1, bus.CODE0};
    total_cnt++;
    if (codes !== 8'b00_01_10_11) $display("FAIL reset_codes: got %b expected 00011011", codes);
    else pass_cnt++;
  endtask

  task automatic test_auto_run();
    logic [11:0] o, e;
    logic [7:0]  codes;
    bus.RUN = 1'b1;
    bus.DIR = 1'b0;
    cyc();
    o = obs(); e = expv(2'd0, 1'b0, 1'b1);
    total_cnt++;
    if (o !== e) $display("FAIL run_entry: got %h expected %h", o, e);
    else pass_cnt++;
    for (int k = 1; k <= 4; k++) begin
      for (int c = 1; c <= 4; c++) begin
        cyc();
        o = obs();
        e = expv((c == 4) ? 2'(k) : 2'(k - 1), (c == 4), 1'b1);
        total_cnt++;
        if (o !== e) $display("FAIL auto_step k%0d c%0d: got %h expected %h", k, c, o, e);
        else pass_cnt++;
        if (k == 1 && c == 4) begin
          codes = {bus.CODE3, bus.CODE2, bus.CODE1, bus.CODE0};
          total_cnt++;
          if (codes !== 8'b01_10_11_00) $display("FAIL auto_codes: got %b expected 01101100", codes);
          else pass_cnt++;
        end
      end
    end
    bus.RUN = 1'b0;
    cyc();
    o = obs(); e = expv(2'd0, 1'b0, 1'b0);
    total_cnt++;
    if (o !== e) $display("FAIL run_exit: got %h expected %h", o, e);
    else pass_cnt++;
  endtask

  task automatic test_step_hold();
    logic [11:0] o, e;
    bus.DIR  = 1'b1;
    bus.STEP = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      o = obs(); e = expv(2'd3, (i == 0), 1'b0);
      total_cnt++;
      if (o !== e) $display("FAIL step_hold cyc%0d: got %h expected %h", i, o, e);
      else pass_cnt++;
    end
    bus.STEP = 1'b0;
    bus.DIR  = 1'b0;
    cyc();
    o = obs(); e = expv(2'd3, 1'b0, 1'b0);
    total_cnt++;
    if (o !== e) $display("FAIL dir_change0: got %h expected %h", o, e);
    else pass_cnt++;
    bus.DIR = 1'b1;
    cyc();
    o = obs();
    total_cnt++;
    if (o !== e) $display("FAIL dir_change1: got %h expected %h", o, e);
    else pass_cnt++;
    bus.DIR = 1'b0;
  endtask

  task automatic test_step_wrap();
    logic [11:0] o, e;
    bus.RUN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      o = obs(); e = expv(2'd3, 1'b0, 1'b1);
      total_cnt++;
      if (o !== e) $display("FAIL sw_count cyc%0d: got %h expected %h", i, o, e);
      else pass_cnt++;
    end
    bus.STEP = 1'b1;
    cyc();
    o = obs(); e = expv(2'd0, 1'b1, 1'b1);
    total_cnt++;
    if (o !== e) $display("FAIL step_and_wrap: got %h expected %h", o, e);
    else pass_cnt++;
    bus.STEP = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      o = obs(); e = expv((c == 4) ? 2'd1 : 2'd0, (c == 4), 1'b1);
      total_cnt++;
      if (o !== e) $display("FAIL sw_next c%0d: got %h expected %h", c, o, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_load_priority();
    logic [11:0] o, e;
    for (int i = 0; i < 3; i++) begin
      cyc();
      o = obs(); e = expv(2'd1, 1'b0, 1'b1);
      total_cnt++;
      if (o !== e) $display("FAIL ld_count cyc%0d: got %h expected %h", i, o, e);
      else pass_cnt++;
    end
    bus.LOAD     = 1'b1;
    bus.LOAD_VAL = 2'd2;
    bus.STEP     = 1'b1;
    cyc();
    o = obs(); e = expv(2'd2, 1'b1, 1'b1);
    total_cnt++;
    if (o !== e) $display("FAIL load_step_wrap: got %h expected %h", o, e);
    else pass_cnt++;
    bus.LOAD = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      o = obs(); e = expv((c == 4) ? 2'd3 : 2'd2, (c == 4), 1'b1);
      total_cnt++;
      if (o !== e) $display("FAIL ld_next c%0d: got %h expected %h", c, o, e);
      else pass_cnt++;
    end
    bus.RUN      = 1'b0;
    bus.STEP     = 1'b0;
    bus.LOAD     = 1'b1;
    bus.LOAD_VAL = 2'd3;
    cyc();
    o = obs(); e = expv(2'd3, 1'b0, 1'b0);
    total_cnt++;
    if (o !== e) $display("FAIL load_same: got %h expected %h", o, e);
    else pass_cnt++;
    bus.LOAD = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [11:0] o, e;
    bus.DIR = 1'b0;
    bus.RUN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      o = obs(); e = expv(2'd3, 1'b0, 1'b1);
      total_cnt++;
      if (o !== e) $display("FAIL rm_count cyc%0d: got %h expected %h", i, o, e);
      else pass_cnt++;
    end
    rst = 1'b1;
    cyc();
    o = obs(); e = expv(2'd0, 1'b0, 1'b0);
    total_cnt++;
    if (o !== e) $display("FAIL reset_mid: got %h expected %h", o, e);
    else pass_cnt++;
    rst = 1'b0;
    cyc();
    o = obs(); e = expv(2'd0, 1'b0, 1'b1);
    total_cnt++;
    if (o !== e) $display("FAIL rm_reentry: got %h expected %h", o, e);
    else pass_cnt++;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      o = obs(); e = expv((c == 4) ? 2'd1 : 2'd0, (c == 4), 1'b1);
      total_cnt++;
      if (o !== e) $display("FAIL rm_first_step c%0d: got %h expected %h", c, o, e);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt     = 0;
    total_cnt    = 0;
    rst          = 1'b1;
    bus.RUN      = 1'b0;
    bus.DIR      = 1'b0;
    bus.STEP     = 1'b0;
    bus.LOAD     = 1'b0;
    bus.LOAD_VAL = 2'd0;
    test_reset();
    test_auto_run();
    test_step_hold();
    test_step_wrap();
    test_load_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
